mem_port_arbiter: RTL

- Shares the memory's single write port and one read port among NREQ requesters (instruction fetch, operand fetch, writeback, loader).
- Per-channel round-robin grant; read responses are routed back to the originating requester after a fixed read latency.
- Sits between the cpu-side clients and the memory block; drives the memory's read/outaddr and write/inaddr/indata signals.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port and one write port among NREQ clients.
// Read responses are steered back to the issuing client through a RD_LAT-deep tag pipeline.
module mem_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 14,
    parameter int DW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [NREQ-1:0]   rd_req,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]   rd_gnt,
    output logic [NREQ-1:0]   rd_valid,
    output logic [DW-1:0]     rd_data,
    input  logic [NREQ-1:0]   wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   wr_gnt,
    output logic              m_read,
    output logic [AW-1:0]     m_outaddr,
    input  logic [DW-1:0]     m_outdata,
    output logic              m_write,
    output logic [AW-1:0]     m_inaddr,
    output logic [DW-1:0]     m_indata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [IW-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t i);
        int n;
        n = int'(i) + 1;
        if (n >= NREQ) n = 0;
        return idx_t'(n);
    endfunction

    // Returns {found, winner}: first asserted request at or after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req, input idx_t ptr);
        logic found;
        idx_t win;
        int   j;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = idx_t'(j);
            end
        end
        return {found, win};
    endfunction

    idx_t              rd_ptr_q, rd_ptr_d;
    idx_t              wr_ptr_q, wr_ptr_d;
    logic              wr_found, rd_found;
    idx_t              wr_win, rd_win;
    logic [NREQ-1:0]   wr_cand, rd_cand;
    logic [RD_LAT-1:0] tag_vld_q;
    idx_t              tag_idx_q [RD_LAT];

    always_comb begin
        wr_cand  = stall ? '0 : wr_req;
        {wr_found, wr_win} = rr_pick(wr_cand, wr_ptr_q);
        wr_gnt   = '0;
        m_write  = wr_found;
        m_inaddr = '0;
        m_indata = '0;
        if (wr_found) begin
            wr_gnt[wr_win] = 1'b1;
            m_inaddr       = wr_addr[wr_win*AW +: AW];
            m_indata       = wr_data[wr_win*DW +: DW];
        end
        wr_ptr_d = wr_found ? wrap_inc(wr_win) : wr_ptr_q;
    end

    // A read colliding with this cycle's granted write waits one cycle so it sees the new data.
    always_comb begin
        rd_cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_cand[i] = rd_req[i] && !stall &&
                         !(wr_found && (rd_addr[i*AW +: AW] == m_inaddr));
        end
        {rd_found, rd_win} = rr_pick(rd_cand, rd_ptr_q);
        rd_gnt    = '0;
        m_read    = rd_found;
        m_outaddr = '0;
        if (rd_found) begin
            rd_gnt[rd_win] = 1'b1;
            m_outaddr      = rd_addr[rd_win*AW +: AW];
        end
        rd_ptr_d = rd_found ? wrap_inc(rd_win) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            tag_vld_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tag_vld_q[0] <= m_read;
            for (int k = 1; k < RD_LAT; k++) tag_vld_q[k] <= tag_vld_q[k-1];
        end
    end

    // Tag indices are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_idx_q[0] <= rd_win;
        for (int k = 1; k < RD_LAT; k++) tag_idx_q[k] <= tag_idx_q[k-1];
    end

    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rd_valid[tag_idx_q[RD_LAT-1]] = 1'b1;
            rd_data                       = m_outdata;
        end
    end

endmodule
